// File: rtl/sync_fifo_lvl.sv
//==============================================================================
// Module   : sync_fifo_lvl
// Brief    : Single-clock FIFO with occupancy count, almost-full/empty levels
//            and sticky overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for
//            first-word-fall-through output; otherwise dout is registered.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_fifo_lvl #(
  parameter int WIDTH     = 8,
  parameter int LOGSIZE   = 4,
  parameter int AF_THRESH = (1 << LOGSIZE) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   din,
  input  logic               wr,
  input  logic               rd,
  output logic [WIDTH-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [LOGSIZE:0]   count,
  output logic               overflow,
  output logic               underflow
);

  localparam int               c_size     = 1 << LOGSIZE;
  localparam logic [LOGSIZE:0] c_full_cnt = (LOGSIZE+1)'(c_size);
  localparam logic [LOGSIZE:0] c_af       = (LOGSIZE+1)'(AF_THRESH);
  localparam logic [LOGSIZE:0] c_ae       = (LOGSIZE+1)'(AE_THRESH);
  localparam logic [LOGSIZE:0] c_cnt_one  = (LOGSIZE+1)'(1);
  localparam logic [LOGSIZE-1:0] c_ptr_one = LOGSIZE'(1);

  logic [WIDTH-1:0]   r_mem [c_size];
  logic [LOGSIZE-1:0] r_wptr;
  logic [LOGSIZE-1:0] r_rptr;
  logic [LOGSIZE:0]   r_count;
  logic               r_overflow;
  logic               r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_full  = (r_count == c_full_cnt);
  assign w_empty = (r_count == '0);
  assign w_rd_ok = rd && !w_empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign w_wr_ok = wr && (!w_full || w_rd_ok);

  always_ff @(posedge clk) begin
    if (!reset && w_wr_ok) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + c_ptr_one;
      if (w_rd_ok) r_rptr <= r_rptr + c_ptr_one;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      if (wr && !w_wr_ok) r_overflow  <= 1'b1;
      if (rd && w_empty)  r_underflow <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = w_empty ? '0 : r_mem[r_rptr];
`else
  logic [WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
    end else if (w_rd_ok) begin
      r_dout <= r_mem[r_rptr];
    end
  end

  assign dout = r_dout;
`endif

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_af);
  assign almost_empty = (r_count <= c_ae);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_lvl.sv
//==============================================================================
// Module   : tb_sync_fifo_lvl
// Brief    : Directed self-checking bench for sync_fifo_lvl (SIZE=4); follows
//            the SYNC_FIFO_FWFT_EN setting of the design build.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sync_fifo_lvl;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       wr;
  logic       rd;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks;
  int n_errors;

  sync_fifo_lvl #(
    .WIDTH     (8),
    .LOGSIZE   (2),
    .AF_THRESH (2),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .wr           (wr),
    .rd           (rd),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen at that point too.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
    wr  = 1'b0;
    rd  = 1'b0;
  endtask

  // FWFT shows the head before the read; registered mode shows it after.
  task automatic pop(input string tag, input logic [7:0] exp, input logic w, input logic [7:0] d);
`ifdef SYNC_FIFO_FWFT_EN
    check_eq(tag, dout, exp);
    cycle(w, 1'b1, d);
`else
    cycle(w, 1'b1, d);
    check_eq(tag, dout, exp);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_ae", almost_empty, 1);
    check_eq("rst_af", almost_full, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_unf", underflow, 0);
    check_eq("rst_dout", dout, 0);

    // Fill to full, then overflow.
    cycle(1'b1, 1'b0, 8'h11);
    check_eq("w1_count", count, 1);
    check_eq("w1_empty", empty, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check_eq("fwft_latency", dout, 8'h11);
`else
    check_eq("reg_no_read", dout, 8'h00);
`endif
    cycle(1'b1, 1'b0, 8'h22);
    check_eq("w2_af", almost_full, 1);
    cycle(1'b1, 1'b0, 8'h33);
    check_eq("w3_ae", almost_empty, 0);
    cycle(1'b1, 1'b0, 8'h44);
    check_eq("fill_count", count, 4);
    check_eq("fill_full", full, 1);
    check_eq("fill_af", almost_full, 1);
    check_eq("fill_ovf", overflow, 0);
    cycle(1'b1, 1'b0, 8'h55);
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_count", count, 4);

    // Simultaneous write and read while full.
    pop("full_rdwr", 8'h11, 1'b1, 8'h55);
    check_eq("full_rdwr_count", count, 4);
    check_eq("full_rdwr_ovf", overflow, 1);
    pop("drain0", 8'h22, 1'b0, 8'h00);
    pop("drain1", 8'h33, 1'b0, 8'h00);
    pop("drain2", 8'h44, 1'b0, 8'h00);
    pop("drain3", 8'h55, 1'b0, 8'h00);
    check_eq("drain_count", count, 0);
    check_eq("drain_empty", empty, 1);
    check_eq("drain_unf", underflow, 0);

    // Underflow, then read+write on empty.
    cycle(1'b0, 1'b1, 8'h00);
    check_eq("unf_set", underflow, 1);
    check_eq("unf_count", count, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check_eq("unf_dout", dout, 8'h00);
`else
    check_eq("unf_dout_hold", dout, 8'h55);
`endif
    cycle(1'b1, 1'b1, 8'hA5);
    check_eq("rdwr_empty_unf", underflow, 1);
    check_eq("rdwr_empty_count", count, 1);
    pop("rdwr_empty_data", 8'hA5, 1'b0, 8'h00);
    check_eq("rdwr_empty_after", count, 0);

    // Batches of 3 across pointer wrap.
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 3; i++) begin
        cycle(1'b1, 1'b0, 8'(b * 3 + i + 1));
        check_eq($sformatf("b%0d_wcnt%0d", b, i), count, i + 1);
        check_eq($sformatf("b%0d_wae%0d", b, i), almost_empty, (i + 1 <= 2) ? 1 : 0);
      end
      for (int i = 0; i < 3; i++) begin
        pop($sformatf("b%0d_data%0d", b, i), 8'(b * 3 + i + 1), 1'b0, 8'h00);
        check_eq($sformatf("b%0d_rcnt%0d", b, i), count, 2 - i);
      end
    end

    // Reset mid-operation with a write pending.
    cycle(1'b1, 1'b0, 8'h01);
    cycle(1'b1, 1'b0, 8'h02);
    cycle(1'b1, 1'b0, 8'h03);
    check_eq("pre_rst_count", count, 3);
    reset = 1'b1;
    wr    = 1'b1;
    din   = 8'h77;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr    = 1'b0;
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_empty", empty, 1);
    check_eq("mid_rst_ovf", overflow, 0);
    check_eq("mid_rst_unf", underflow, 0);
    check_eq("mid_rst_dout", dout, 0);
    cycle(1'b1, 1'b0, 8'h99);
    check_eq("post_rst_count", count, 1);
    pop("post_rst_data", 8'h99, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_lvl.md
# sync_fifo_lvl

Parametrised synchronous FIFO with full-depth capacity, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the general-purpose buffer for single-clock datapaths between producer and consumer stages. It has a compile-time choice between first-word-fall-through and registered-read output.

## Interface
- WIDTH, 8, data bits per entry
- LOGSIZE, 4, depth is SIZE = 1<<LOGSIZE entries, all usable
- AF_THRESH, SIZE-2, almost_full asserted when count >= AF_THRESH (legal 1..SIZE)
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (legal 0..SIZE-1)

- clk  input  1  clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; empties FIFO and clears error flags
- din  input  WIDTH  write data
- wr  input  1  write request
- rd  input  1  read request
- dout  output  WIDTH  read data (see Configuration)
- full  output  1  count == SIZE
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_THRESH
- almost_empty  output  1  count <= AE_THRESH
- count  output  LOGSIZE+1  current occupancy, 0..SIZE
- overflow  output  1  sticky: write requested while rejected
- underflow  output  1  sticky: read requested while empty

## Operation
- Storage: SIZE x WIDTH array. wptr/rptr are LOGSIZE bits and wrap modulo SIZE. count is a separate LOGSIZE+1-bit register.
- Read accepted (rd_ok) iff rd && !empty. On accept, rptr increments.
- Write accepted (wr_ok) iff wr && (!full || rd_ok). A write to a full FIFO with a simultaneous accepted read succeeds. On accept, din is stored at wptr and wptr increments.
- count next value: +1 if wr_ok && !rd_ok; -1 if rd_ok && !wr_ok; otherwise unchanged.
- Write while empty with rd: the read is rejected and underflow is set. The write is still accepted and count becomes 1.
- overflow sets on wr && !wr_ok. underflow sets on rd && empty. Both hold until reset. Neither flag affects pointers.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count. They are glitch-free relative to clk.
- Reset values: wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (given legal AF_THRESH), overflow=0, underflow=0, dout=0. Array contents are not reset.
- Reset asserted mid-operation discards all contents in the same edge. wr and rd in a reset cycle are ignored and do not set error flags.

## Timing
- Write-to-visible latency: an entry written at edge N makes empty=0 and count update after edge N. It is readable from cycle N+1.
- Read latency is per Configuration.
- Throughput: one write and one read per cycle sustained, including at full and at count=1.
- Pointer wrap from SIZE-1 to 0 needs no bubble.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through.
  - dout = mem[rptr] combinationally whenever !empty; rd acknowledges the displayed word.
  - When empty, dout is 0.
- Not defined: registered read.
  - On an accepted read at edge N, dout loads mem[rptr] and is valid from cycle N+1 onward.
  - dout holds its value until the next accepted read.
  - A rejected read leaves dout unchanged.

## Test plan
- Reset, then WIDTH=8, LOGSIZE=2. Write 0x11,0x22,0x33,0x44 -> count=4, full=1, almost_full=1, overflow=0. Fifth write 0x55 -> overflow=1, count stays 4.
- From full, assert wr=1 (0x55) and rd=1 together -> read returns 0x11, 0x55 is stored, count stays 4, overflow unchanged. Drain -> 0x22,0x33,0x44,0x55 in order.
- On an empty FIFO, rd=1 alone -> underflow=1, count=0. Next rd+wr(0xA5) -> underflow stays 1, count=1. Read -> dout=0xA5.
- Push/pop 3 entries per batch for 10 batches (pointer wrap) -> data order preserved. count traces 0..3..0 and almost_empty toggles at count 2->3.
- Fill to 3, then assert reset with wr=1 -> count=0, empty=1, overflow=0, underflow=0, dout=0. The write is discarded.
- Timing check in both macro builds:
  - FWFT: dout=0x11 the cycle after the write.
  - Registered: dout=0x11 the cycle after rd is accepted.
